// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types for the SDRAM command arbiter.
//   - command codes presented on sys_cmd
//   - arbiter FSM states and transaction owners
//   - beat counter width
//   - vid_addr(): video fetch pointer to 18-bit word address
package sdram_arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_WR  = 2'b01,   // write 256 B
    CMD_RDV = 2'b10,   // read 32 B (video)
    CMD_RDL = 2'b11    // read 256 B (cache line)
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_WR  = 2'd1,
    OWN_RD  = 2'd2
  } owner_e;

  // Upper pointer bits are inverted so the frame is fetched downward from
  // the base in 8-word units; the 15-bit sum wraps naturally.
  function automatic logic [17:0] vid_addr(input logic [14:0] base,
                                           input logic [11:0] ptr);
    logic [14:0] s;
    s = base + {3'b000, ~ptr[11:2], ptr[1:0]};
    return {s, 3'b000};
  endfunction

endpackage

// File: rtl/vid_pack.sv
// vid_pack: packs pairs of 16-bit video read beats into 32-bit queue words.
// Ports:
//   clk, rst      clock, async active-low reset
//   beat_i        owner-qualified video read beat
//   clear_i       restart pairing (new video grant)
//   din_i[15:0]   beat data
//   vq_data_o     registered {odd beat, even beat}
//   vq_wren_o     one-cycle write strobe, cycle after the odd beat
module vid_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        beat_i,
  input  logic        clear_i,
  input  logic [15:0] din_i,
  output logic [31:0] vq_data_o,
  output logic        vq_wren_o
);

  logic        phase_q;
  logic [15:0] low_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= 1'b0;
      low_q     <= '0;
      vq_data_o <= '0;
      vq_wren_o <= 1'b0;
    end else begin
      vq_wren_o <= 1'b0;
      if (clear_i) begin
        phase_q <= 1'b0;
      end else if (beat_i) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          low_q <= din_i;
        end else begin
          vq_data_o <= {din_i, low_q};
          vq_wren_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: shares the single SDRAM command port between video
// refill, cache write-back and cache line fill, and steers beats.
// Ports:
//   clk, rst                  SDRAM clock, async active-low reset
//   vid_req/wr_req/rd_req     requests (priority video > write-back > fill)
//   wr_line/rd_line           cache line addresses
//   sys_cmd/sys_addr          registered command and word address
//   sys_cmd_ack               controller acknowledge code
//   sys_rd/wr_data_valid      beat handshakes, sys_dout read data
//   cache_write_data          fill beat strobe (combinational)
//   cache_read_data           write-back beat strobe (combinational)
//   vq_data/vq_wren           packed video words
//   vidadr                    video fetch pointer
//   busy, proto_err           transaction in flight, sticky protocol error
//   vsync                     frame sync, only with VID_RESYNC_EN defined
// Optional feature macro: VID_RESYNC_EN (vsync rising edge resets vidadr
// at the next IDLE cycle, ahead of arbitration).
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter logic [14:0] VID_BASE   = 15'h6FF8,
  parameter int          VID_LAST   = 3071,
  parameter int          VID_BEATS  = 16,
  parameter int          LINE_BEATS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_req,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [11:0] wr_line,
  input  logic [11:0] rd_line,
  output logic [1:0]  sys_cmd,
  output logic [17:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_write_data,
  output logic        cache_read_data,
  output logic [31:0] vq_data,
  output logic        vq_wren,
  output logic [11:0] vidadr,
`ifdef VID_RESYNC_EN
  input  logic        vsync,
`endif
  output logic        busy,
  output logic        proto_err
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [17:0]      addr_q, addr_d;
  logic [11:0]      vptr_q, vptr_d, vptr_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perr_q, perr_d;
  logic             vid_clr, resync;
  logic             in_xfer, rd_beat, wr_beat, any_valid;

`ifdef VID_RESYNC_EN
  logic vsync_q, pend_q;
  // Pending resync survives any transaction and fires on the next IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      pend_q  <= (vsync & ~vsync_q) | (pend_q & (state_q != IDLE));
    end
  end
  assign resync = pend_q & (state_q == IDLE);
`else
  assign resync = 1'b0;
`endif

  // Pointer as seen by this cycle's arbitration.
  assign vptr_eff = resync ? 12'd0 : vptr_q;

  assign in_xfer   = (state_q == XFER);
  assign rd_beat   = in_xfer & (owner_q != OWN_WR) & sys_rd_data_valid;
  assign wr_beat   = in_xfer & (owner_q == OWN_WR) & sys_wr_data_valid;
  assign any_valid = sys_rd_data_valid | sys_wr_data_valid;

  assign cache_write_data = rd_beat & (owner_q == OWN_RD);
  assign cache_read_data  = wr_beat;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    vptr_d  = vptr_eff;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    vid_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid || sys_cmd_ack != CMD_NOP) perr_d = 1'b1;
        if (vid_req) begin
          owner_d = OWN_VID;
          cmd_d   = CMD_RDV;
          addr_d  = vid_addr(VID_BASE, vptr_eff);
          vid_clr = 1'b1;
          state_d = REQ;
        end else if (wr_req) begin
          owner_d = OWN_WR;
          cmd_d   = CMD_WR;
          addr_d  = {wr_line, 6'b0};
          state_d = REQ;
        end else if (rd_req) begin
          owner_d = OWN_RD;
          cmd_d   = CMD_RDL;
          addr_d  = {rd_line, 6'b0};
          state_d = REQ;
        end
      end
      REQ: begin
        if (any_valid) perr_d = 1'b1;
        if (sys_cmd_ack == cmd_q) begin
          cmd_d   = CMD_NOP;
          state_d = XFER;
          if (owner_q == OWN_VID) begin
            cnt_d  = CNT_W'(VID_BEATS);
            vptr_d = (vptr_q == 12'(VID_LAST)) ? 12'd0 : vptr_q + 12'd1;
          end else begin
            cnt_d  = CNT_W'(LINE_BEATS);
          end
        end else if (sys_cmd_ack != CMD_NOP) begin
          perr_d = 1'b1;
        end
      end
      XFER: begin
        if (rd_beat || wr_beat) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_VID;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      vptr_q  <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      vptr_q  <= vptr_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  vid_pack u_vid_pack (
    .clk       (clk),
    .rst       (rst),
    .beat_i    (rd_beat & (owner_q == OWN_VID)),
    .clear_i   (vid_clr),
    .din_i     (sys_dout),
    .vq_data_o (vq_data),
    .vq_wren_o (vq_wren)
  );

  assign sys_cmd   = cmd_q;
  assign sys_addr  = addr_q;
  assign vidadr    = vptr_eff;
  assign busy      = (state_q != IDLE);
  assign proto_err = perr_q;

endmodule
